frame_parity_unit: RTL and testbench

//  Multi-lane, frame-based parity generator/checker with valid/ready handshakes.

---
 rtl/frame_parity_unit_pkg.sv | 16 +
 rtl/frame_parity_unit_lane_parity.sv | 13 +
 rtl/frame_parity_unit.sv | 106 ++++++++++
 tb/tb_frame_parity_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_parity_unit_pkg.sv
// Shared definitions for the frame parity unit: FSM state encoding and the
// beat-counter width helper.
package frame_parity_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Counter must represent 0..max_beats inclusive.
  function automatic int unsigned beat_cnt_w(input int unsigned max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/frame_parity_unit_lane_parity.sv
// Combinational XOR reduction of one parity lane.
module lane_parity #(
  parameter int unsigned width = 8
) (
  input  logic [width-1:0] lane,
  output logic             par
);

  always_comb begin
    par = ^lane;
  end

endmodule

// File: rtl/frame_parity_unit.sv
// Multi-lane frame parity generator/checker with valid/ready on both sides.
// One registered result (parity, per-lane error, overrun, beat count) per frame.
module frame_parity_unit
  import frame_parity_unit_pkg::*;
#(
  parameter int unsigned width     = 8,
  parameter int unsigned lanes     = 1,
  parameter int unsigned max_beats = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_odd,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic [lanes*width-1:0]               i_data,
  input  logic                                 i_last,
  input  logic                                 i_check,
  input  logic [lanes-1:0]                     i_parity,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [lanes-1:0]                     o_parity,
  output logic [lanes-1:0]                     o_error,
  output logic                                 o_overrun,
  output logic [beat_cnt_w(max_beats)-1:0]     o_beats
);

  localparam int unsigned CW      = beat_cnt_w(max_beats);
  localparam logic [CW-1:0] MAX_CNT = CW'(max_beats);

  state_t           state_q, state_d;
  logic [lanes-1:0] acc_q, acc_d;
  logic [lanes-1:0] beat_par;
  logic             odd_q, odd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept, first, close, load_result;
  logic [lanes-1:0] par_d, err_d;

  for (genvar k = 0; k < lanes; k++) begin : g_lane
    lane_parity #(.width(width)) u_lane (
      .lane (i_data[k*width +: width]),
      .par  (beat_par[k])
    );
  end

  // A beat is the first of its frame whenever we are not mid-frame; this
  // includes the RESULT cycle in which the previous result is consumed.
  always_comb begin
    o_valid     = (state_q == RESULT);
    o_ready     = !o_valid || i_ready;
    accept      = i_valid && o_ready;
    first       = (state_q != ACCUM);
    acc_d       = first ? beat_par : (acc_q ^ beat_par);
    cnt_d       = first ? CW'(1) : (cnt_q + CW'(1));
    odd_d       = first ? i_odd : odd_q;
    close       = i_last || (cnt_d == MAX_CNT);
    par_d       = acc_d ^ {lanes{odd_d}};
    err_d       = (i_last && i_check) ? (par_d ^ i_parity) : '0;
    state_d     = state_q;
    load_result = 1'b0;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          state_d     = close ? RESULT : ACCUM;
          load_result = close;
        end
      end
      RESULT: begin
        if (accept) begin
          state_d     = close ? RESULT : ACCUM;
          load_result = close;
        end else if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      odd_q     <= 1'b0;
      cnt_q     <= '0;
      o_parity  <= '0;
      o_error   <= '0;
      o_overrun <= 1'b0;
      o_beats   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        odd_q <= odd_d;
      end
      if (load_result) begin
        o_parity  <= par_d;
        o_error   <= err_d;
        o_overrun <= !i_last;
        o_beats   <= cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_frame_parity_unit.sv
// Bench for frame_parity_unit: three instances (1 lane/16 beats, 2 lanes/4
// beats, 1 lane/1 beat) share one stimulus stream and are checked against a
// ones-counting frame model every cycle.
module tb_frame_parity_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, odd, valid, last, check_in, ready;
  logic [15:0] data;
  logic [1:0]  par;

  logic       r0, r1, r2, v0, v1, v2, ov0, ov1, ov2;
  logic       p0, p2, e0, e2;
  logic [1:0] p1, e1;
  logic [4:0] b0;
  logic [2:0] b1;
  logic [0:0] b2;

  frame_parity_unit #(.width(8), .lanes(1), .max_beats(16)) d0 (
    .clk(clk), .rst(rst), .i_odd(odd), .i_valid(valid), .o_ready(r0),
    .i_data(data[7:0]), .i_last(last), .i_check(check_in), .i_parity(par[0]),
    .o_valid(v0), .i_ready(ready), .o_parity(p0), .o_error(e0),
    .o_overrun(ov0), .o_beats(b0)
  );

  frame_parity_unit #(.width(8), .lanes(2), .max_beats(4)) d1 (
    .clk(clk), .rst(rst), .i_odd(odd), .i_valid(valid), .o_ready(r1),
    .i_data(data), .i_last(last), .i_check(check_in), .i_parity(par),
    .o_valid(v1), .i_ready(ready), .o_parity(p1), .o_error(e1),
    .o_overrun(ov1), .o_beats(b1)
  );

  frame_parity_unit #(.width(8), .lanes(1), .max_beats(1)) d2 (
    .clk(clk), .rst(rst), .i_odd(odd), .i_valid(valid), .o_ready(r2),
    .i_data(data[7:0]), .i_last(last), .i_check(check_in), .i_parity(par[0]),
    .o_valid(v2), .i_ready(ready), .o_parity(p2), .o_error(e2),
    .o_overrun(ov2), .o_beats(b2)
  );

  logic       dv[3], dr[3], dov[3];
  logic [1:0] dp[3], de[3];
  logic [4:0] db[3];
  assign dv[0] = v0;  assign dv[1] = v1;  assign dv[2] = v2;
  assign dr[0] = r0;  assign dr[1] = r1;  assign dr[2] = r2;
  assign dov[0] = ov0; assign dov[1] = ov1; assign dov[2] = ov2;
  assign dp[0] = {1'b0, p0}; assign dp[1] = p1; assign dp[2] = {1'b0, p2};
  assign de[0] = {1'b0, e0}; assign de[1] = e1; assign de[2] = {1'b0, e2};
  assign db[0] = b0; assign db[1] = {2'b00, b1}; assign db[2] = {4'b0000, b2};

  localparam int LANES_M[3] = '{1, 2, 1};
  localparam int MAXB_M[3]  = '{16, 4, 1};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h at %0t",
                  name, inst, act, exp, $time);
  endtask

  // Model state: frame in progress, ones counted per lane, pending result.
  bit         live;
  bit         mv[3], infr[3], modd[3], eovr[3];
  int         cnt[3], eb[3];
  int         ones[3][2];
  logic [1:0] epar[3], eerr[3];
  int         n_res0;

  initial begin
    live   = 1'b0;
    n_res0 = 0;
    forever begin
      @(negedge clk);
      if (live) begin
        for (int i = 0; i < 3; i++) begin
          check("o_ready", i, dr[i], !mv[i] || ready);
          check("o_valid", i, dv[i], mv[i]);
          if (mv[i]) begin
            check("o_parity", i, dp[i], epar[i]);
            check("o_error", i, de[i], eerr[i]);
            check("o_overrun", i, dov[i], eovr[i]);
            check("o_beats", i, db[i], eb[i]);
          end
        end
        if (dv[0] && ready) n_res0++;
      end
      // Advance the model with the inputs the next rising edge will sample.
      for (int i = 0; i < 3; i++) begin
        bit rdy;
        if (rst) begin
          mv[i]   = 1'b0;
          infr[i] = 1'b0;
        end else begin
          rdy = !mv[i] || ready;
          if (mv[i] && ready) mv[i] = 1'b0;
          if (valid && rdy) begin
            if (!infr[i]) begin
              infr[i] = 1'b1;
              cnt[i]  = 0;
              ones[i][0] = 0;
              ones[i][1] = 0;
              modd[i] = odd;
            end
            cnt[i]++;
            for (int l = 0; l < LANES_M[i]; l++)
              ones[i][l] += $countones(data[l*8 +: 8]);
            if (last || cnt[i] == MAXB_M[i]) begin
              mv[i]   = 1'b1;
              infr[i] = 1'b0;
              eovr[i] = !last;
              eb[i]   = cnt[i];
              for (int l = 0; l < 2; l++) begin
                if (l < LANES_M[i]) begin
                  epar[i][l] = ((ones[i][l] % 2) == 1) ^ modd[i];
                  eerr[i][l] = last && check_in && (epar[i][l] != par[l]);
                end else begin
                  epar[i][l] = 1'b0;
                  eerr[i][l] = 1'b0;
                end
              end
            end
          end
        end
      end
      if (rst) live = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d, input logic l, input logic c,
                      input logic [1:0] p, input logic o);
    data = d; last = l; check_in = c; par = p; odd = o; valid = 1'b1;
    tick();
    valid = 1'b0; last = 1'b0; check_in = 1'b0;
  endtask

  initial begin
    int start;
    rst = 1'b1; odd = 1'b0; valid = 1'b0; last = 1'b0; check_in = 1'b0;
    ready = 1'b1; data = '0; par = '0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_valid", i, dv[i], 1'b0);
      check("rst_ready", i, dr[i], 1'b1);
      check("rst_parity", i, dp[i], 2'b00);
      check("rst_error", i, de[i], 2'b00);
      check("rst_overrun", i, dov[i], 1'b0);
      check("rst_beats", i, db[i], 5'd0);
    end

    // Single even beat 0x07
    beat(16'h0007, 1'b1, 1'b0, 2'b00, 1'b0);
    #1;
    check("t1_valid", 0, v0, 1'b1);
    check("t1_parity", 0, p0, 1'b1);
    check("t1_beats", 0, b0, 5'd1);
    check("t1_model", 0, epar[0], 2'b01);
    check("t1_mb1_ovr", 2, ov2, 1'b0);
    check("t1_mb1_par", 2, p2, 1'b1);

    // Odd mode latched on first beat, i_odd dropped mid-frame
    beat(16'h0001, 1'b0, 1'b0, 2'b00, 1'b1);
    beat(16'h0003, 1'b0, 1'b0, 2'b00, 1'b0);
    beat(16'h00FF, 1'b1, 1'b1, 2'b01, 1'b0);
    #1;
    check("t2_parity", 0, p0, 1'b0);
    check("t2_error", 0, e0, 1'b1);
    check("t2_beats", 0, b0, 5'd3);
    check("t2_par2", 1, p1, 2'b10);
    check("t2_err2", 1, e1, 2'b11);

    // Two lanes, result held under back-pressure
    beat(16'h0103, 1'b0, 1'b0, 2'b00, 1'b0);
    ready = 1'b0;
    beat(16'h0001, 1'b1, 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_valid", 1, v1, 1'b1);
      check("t3_ready", 1, r1, 1'b0);
      check("t3_parity", 1, p1, 2'b11);
      check("t3_beats", 1, b1, 3'd2);
      @(posedge clk);
    end
    #1;
    ready = 1'b1;
    tick();
    #1;
    check("t3_consumed", 1, v1, 1'b0);

    // Overrun at max_beats=4 with check ignored, then next frame
    beat(16'h0F01, 1'b0, 1'b1, 2'b11, 1'b0);
    beat(16'h0002, 1'b0, 1'b1, 2'b11, 1'b0);
    beat(16'h0004, 1'b0, 1'b1, 2'b11, 1'b0);
    beat(16'h0708, 1'b0, 1'b1, 2'b11, 1'b0);
    #1;
    check("t4_valid", 1, v1, 1'b1);
    check("t4_overrun", 1, ov1, 1'b1);
    check("t4_beats", 1, b1, 3'd4);
    check("t4_error", 1, e1, 2'b00);
    check("t4_parity", 1, p1, 2'b10);
    check("t4_mb1_ovr", 2, ov2, 1'b1);
    beat(16'h0010, 1'b0, 1'b0, 2'b00, 1'b0);
    beat(16'h0020, 1'b1, 1'b0, 2'b00, 1'b0);
    #1;
    check("t4_next_ovr", 1, ov1, 1'b0);
    check("t4_next_beats", 1, b1, 3'd2);
    check("t4_next_par", 1, p1, 2'b00);
    check("t4_long_beats", 0, b0, 5'd6);
    check("t4_long_par", 0, p0, 1'b0);

    // Back-to-back single-beat frames
    tick();
    start = n_res0;
    for (int k = 0; k < 8; k++)
      beat(16'(k * 37 + 5), 1'b1, k[0], 2'(k), k[1]);
    tick();
    check("t5_results", 0, n_res0 - start, 8);

    // Reset mid-frame
    beat(16'h00FF, 1'b0, 1'b0, 2'b00, 1'b0);
    beat(16'h0001, 1'b0, 1'b0, 2'b00, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t6a_valid", i, dv[i], 1'b0);
      check("t6a_ready", i, dr[i], 1'b1);
    end
    beat(16'h0001, 1'b1, 1'b0, 2'b00, 1'b0);
    #1;
    check("t6a_parity", 0, p0, 1'b1);
    check("t6a_beats", 0, b0, 5'd1);
    check("t6a_par2", 1, p1, 2'b01);
    tick();

    // Reset with a result pending
    ready = 1'b0;
    beat(16'h0003, 1'b1, 1'b0, 2'b00, 1'b0);
    #1;
    check("t6b_pending", 0, v0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t6b_valid", i, dv[i], 1'b0);
      check("t6b_ready", i, dr[i], 1'b1);
    end
    beat(16'h0100, 1'b1, 1'b0, 2'b00, 1'b0);
    #1;
    check("t6b_par2", 1, p1, 2'b10);
    check("t6b_beats2", 1, b1, 3'd1);
    check("t6b_parity", 0, p0, 1'b0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
